// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester ids, FSM states
// and the default memory geometry.
package dmem_arbiter_pkg;

   localparam int unsigned DMEM_ADDR_W = 14;
   localparam int unsigned DMEM_DATA_W = 32;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU has priority,
// the loader is protected from starvation and can lock the memory for uploads.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DMEM_ADDR_W,
   parameter int unsigned DATA_W     = DMEM_DATA_W,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              ld_req_i,
   input  logic              ld_we_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_wdata_i,
   input  logic              ld_lock_i,
   output logic              ld_gnt_o,
   output logic              ld_rvalid_o,
   output logic [DATA_W-1:0] ld_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              locked_o
);

   localparam logic [3:0] LimC = 4'(STARVE_LIM);

   arb_state_e state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_owner_q, rd_owner_d;
   logic       cpu_gnt, ld_gnt;
   logic       starved;

   assign starved = (wait_cnt_q == LimC);

   // Grants are held low while reset is asserted, even with requests present.
   always_comb begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (rst_ni) begin
         if (state_q == LOCK) begin
            ld_gnt = ld_req_i;
         end else if (cpu_req_i && ld_req_i) begin
            ld_gnt  = starved;
            cpu_gnt = ~starved;
         end else begin
            cpu_gnt = cpu_req_i;
            ld_gnt  = ld_req_i;
         end
      end
   end

   always_comb begin
      mem_en_o    = cpu_gnt | ld_gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ld_gnt) begin
         mem_we_o    = ld_we_i;
         mem_addr_o  = ld_addr_i;
         mem_wdata_o = ld_wdata_i;
      end else if (cpu_gnt) begin
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == LOCK || ld_gnt || !ld_req_i) begin
         wait_cnt_d = '0;
      end else if (!starved) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end

      state_d = state_q;
      unique case (state_q)
         ARB:  if (ld_gnt && ld_lock_i) state_d = LOCK;
         LOCK: if (!ld_lock_i) state_d = ARB;
         default: state_d = ARB;
      endcase

      rd_pend_d  = mem_en_o & ~mem_we_o;
      rd_owner_d = rd_pend_d ? (ld_gnt ? REQ_LD : REQ_CPU) : rd_owner_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB;
         wait_cnt_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= REQ_CPU;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   assign cpu_gnt_o    = cpu_gnt;
   assign ld_gnt_o     = ld_gnt;
   assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
   assign locked_o     = (state_q == LOCK);
   assign cpu_rvalid_o = rd_pend_q & (rd_owner_q == REQ_CPU);
   assign ld_rvalid_o  = rd_pend_q & (rd_owner_q == REQ_LD);
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
   assign ld_rdata_o   = ld_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner cases and a
// randomized run against a cycle-level reference model with its own memory.
module tb_dmem_arbiter;

   localparam int LIM = 4;

   logic        clk, rst_n;
   logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
   logic [13:0] cpu_addr, ld_addr;
   logic [31:0] cpu_wdata, ld_wdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid, locked;
   logic [31:0] cpu_rdata, ld_rdata;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] tb_mem [0:16383];
   logic [31:0] mm     [0:16383];

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_LIM(LIM)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid),
      .cpu_rdata_o(cpu_rdata),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
      .ld_lock_i(ld_lock), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .locked_o(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory driven by the arbiter.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   typedef struct {
      logic        creq, cwe;
      logic [13:0] caddr;
      logic [31:0] cwd;
      logic        lreq, lwe;
      logic [13:0] laddr;
      logic [31:0] lwd;
      logic        llock;
      logic        ecg, elg, estall, ecrv;
      logic [31:0] ecrd;
      logic        elrv;
      logic [31:0] elrd;
      logic        elk;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic creq, logic cwe, logic [13:0] caddr, logic [31:0] cwd,
                               logic lreq, logic lwe, logic [13:0] laddr, logic [31:0] lwd,
                               logic llock, logic ecg, logic elg, logic estall,
                               logic ecrv, logic [31:0] ecrd, logic elrv, logic [31:0] elrd,
                               logic elk);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd; v.llock = llock;
      v.ecg = ecg; v.elg = elg; v.estall = estall; v.ecrv = ecrv; v.ecrd = ecrd;
      v.elrv = elrv; v.elrd = elrd; v.elk = elk;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic creq, input logic cwe, input logic [13:0] caddr,
                        input logic [31:0] cwd, input logic lreq, input logic lwe,
                        input logic [13:0] laddr, input logic [31:0] lwd, input logic llock);
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwd; ld_lock = llock;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      chk($sformatf("v%0d cpu_gnt", i), 64'(cpu_gnt), 64'(v.ecg));
      chk($sformatf("v%0d ld_gnt", i), 64'(ld_gnt), 64'(v.elg));
      chk($sformatf("v%0d cpu_stall", i), 64'(cpu_stall), 64'(v.estall));
      chk($sformatf("v%0d cpu_rvalid", i), 64'(cpu_rvalid), 64'(v.ecrv));
      chk($sformatf("v%0d cpu_rdata", i), 64'(cpu_rdata), 64'(v.ecrd));
      chk($sformatf("v%0d ld_rvalid", i), 64'(ld_rvalid), 64'(v.elrv));
      chk($sformatf("v%0d ld_rdata", i), 64'(ld_rdata), 64'(v.elrd));
      chk($sformatf("v%0d locked", i), 64'(locked), 64'(v.elk));
   endtask

   // Reference model state
   int          m_wait;
   bit          m_lock;
   int          m_owner;
   logic [31:0] m_data;

   initial begin
      logic        cq, cw, lq, lw, lk, ec, el;
      logic [13:0] ca, la;
      logic [31:0] cd, ld;
      logic [13:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_we;

      for (int i = 0; i < 16384; i++) tb_mem[i] = 32'h0;
      tb_mem[14'h010] = 32'hDEADBEEF;
      mem_rdata = 32'h0;

      // Reset held with both requesters asserting
      rst_n = 1'b0;
      drive(1, 1, 14'h3FF, 32'h1, 1, 1, 14'h3FE, 32'h2, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst cpu_gnt", 64'(cpu_gnt), 64'd0);
      chk("rst ld_gnt", 64'(ld_gnt), 64'd0);
      chk("rst mem_en", 64'(mem_en), 64'd0);
      chk("rst locked", 64'(locked), 64'd0);
      chk("rst rvalid", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel cpu_gnt", 64'(cpu_gnt), 64'd1);
      chk("rel ld_gnt", 64'(ld_gnt), 64'd0);
      @(posedge clk);

      // CPU read alone
      vecs.push_back(mk(1, 0, 14'h010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0));
      // Contention: four CPU wins then one loader win, twice
      for (int k = 0; k < 10; k++) begin
         logic lwin;
         lwin = (k % 5 == 4);
         vecs.push_back(mk(1, 1, 14'h100, 32'(k), 1, 1, 14'h200, 32'(k), 0,
                           ~lwin, lwin, lwin, 0, 0, 0, 0, 0));
      end
      // Coherence: loader write then CPU read of the same word
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 14'h020, 32'h12345678, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 14'h020, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0));
      // Lock: loader starves four cycles, wins, then owns memory until ld_lock drops
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(1, 1, 14'h300, 32'h55, 1, 1, 14'h000, 32'hA0, 1,
                           1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 14'h300, 32'h55, 1, 1, 14'h000, 32'hA0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 14'h300, 32'h55, 1, 1, 14'h001, 32'hA1, 1, 0, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 14'h300, 32'h55, 1, 1, 14'h002, 32'hA2, 1, 0, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 14'h300, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 14'h300, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      // ld_lock without ld_req must not lock
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 14'h001, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA1, 0));

      foreach (vecs[i]) begin
         #1 drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd, vecs[i].lreq,
                  vecs[i].lwe, vecs[i].laddr, vecs[i].lwd, vecs[i].llock);
         @(negedge clk);
         check_vec(i, vecs[i]);
         @(posedge clk);
      end

      // Reset asserted while a CPU read is in flight
      #1 drive(1, 0, 14'h010, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("midrd cpu_gnt", 64'(cpu_gnt), 64'd1);
      #1 rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk("midrd rvalid a", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrd rvalid b", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
      chk("midrd locked", 64'(locked), 64'd0);
      @(posedge clk);

      // Reset during LOCK with ld_lock still held
      #1 drive(0, 0, 0, 0, 1, 1, 14'h005, 32'h5, 1);
      @(negedge clk);
      chk("lkrst ld_gnt", 64'(ld_gnt), 64'd1);
      @(posedge clk);
      #1 chk("lkrst locked on", 64'(locked), 64'd1);
      rst_n = 1'b0;
      #1 chk("lkrst locked off", 64'(locked), 64'd0);
      chk("lkrst ld_gnt off", 64'(ld_gnt), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("lkrst rel locked", 64'(locked), 64'd0);
      @(posedge clk);
      #1 chk("lkrst still arb", 64'(locked), 64'd0);

      // Randomized run against the reference model
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16384; i++) mm[i] = tb_mem[i];
      m_wait = 0; m_lock = 0; m_owner = -1; m_data = '0;
      cq = 0; lq = 0; lk = 0; cw = 0; lw = 0; ca = '0; la = '0; cd = '0; ld = '0;
      @(posedge clk);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         #1;
         if (!cq && $urandom_range(1, 0) == 1) begin
            cq = 1; cw = 1'($urandom_range(1, 0)); ca = 14'($urandom_range(15, 0)); cd = $urandom;
         end
         if (!lq && $urandom_range(1, 0) == 1) begin
            lq = 1; lw = 1'($urandom_range(1, 0)); la = 14'($urandom_range(15, 0)); ld = $urandom;
         end
         if ($urandom_range(15, 0) == 0) lk = ~lk;
         drive(cq, cw, ca, cd, lq, lw, la, ld, lk);

         if (m_lock) begin
            ec = 0; el = lq;
         end else if (cq && lq) begin
            el = (m_wait == LIM); ec = ~el;
         end else begin
            ec = cq; el = lq;
         end
         e_we = el ? lw : (ec ? cw : 1'b0);
         e_addr = el ? la : (ec ? ca : 14'h0);
         e_wdata = el ? ld : (ec ? cd : 32'h0);

         @(negedge clk);
         chk($sformatf("r%0d cpu_gnt", cyc), 64'(cpu_gnt), 64'(ec));
         chk($sformatf("r%0d ld_gnt", cyc), 64'(ld_gnt), 64'(el));
         chk($sformatf("r%0d cpu_stall", cyc), 64'(cpu_stall), 64'(cq & ~ec));
         chk($sformatf("r%0d mem_en", cyc), 64'(mem_en), 64'(ec | el));
         chk($sformatf("r%0d mem_we", cyc), 64'(mem_we), 64'(e_we));
         chk($sformatf("r%0d mem_addr", cyc), 64'(mem_addr), 64'(e_addr));
         chk($sformatf("r%0d mem_wdata", cyc), 64'(mem_wdata), 64'(e_wdata));
         chk($sformatf("r%0d cpu_rvalid", cyc), 64'(cpu_rvalid), 64'(m_owner == 0));
         chk($sformatf("r%0d cpu_rdata", cyc), 64'(cpu_rdata), 64'((m_owner == 0) ? m_data : 0));
         chk($sformatf("r%0d ld_rvalid", cyc), 64'(ld_rvalid), 64'(m_owner == 1));
         chk($sformatf("r%0d ld_rdata", cyc), 64'(ld_rdata), 64'((m_owner == 1) ? m_data : 0));
         chk($sformatf("r%0d locked", cyc), 64'(locked), 64'(m_lock));

         @(posedge clk);
         if (m_lock) begin
            m_wait = 0;
            m_lock = lk;
         end else begin
            if (el || !lq) m_wait = 0;
            else if (m_wait < LIM) m_wait++;
            m_lock = el && lk;
         end
         m_owner = -1;
         if (ec && !cw) begin m_owner = 0; m_data = mm[ca]; end
         if (el && !lw) begin m_owner = 1; m_data = mm[la]; end
         if (ec && cw) mm[ca] = cd;
         if (el && lw) mm[la] = ld;
         if (ec) cq = 0;
         if (el) lq = 0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
